ps2_transmitter: RTL and testbench
==================================

// Module: ps2_transmitter
// PURPOSE
//   Host-to-device PS/2 transmitter, the send side of the PS/2 link.
//   Takes a byte over a valid/ready handshake and runs the host request-to-send
//   sequence: inhibit the clock, send the start bit, release the clock, then shift
//   out the data bits, odd parity and stop bit on the device-generated clock.
//   Checks the device ACK and reports done or error. Drives the lines open-drain
//   through output enables; the top level makes the pads (oe=1 -> pin driven low).
// PARAMETERS
//   INHIBIT_CYCLES  1200    clk cycles ps2_clk is held low before RTS (>=100us at 12MHz)
//   TIMEOUT_CYCLES  240000  max clk cycles between device clock edges before abort
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  synchronous reset, active low
//   tx_data      in   8  byte to send, LSB first
//   tx_valid     in   1  request; accepted when tx_valid && tx_ready
//   tx_ready     out  1  high only in IDLE
//   tx_busy      out  1  high in every state except IDLE; gates the PS/2 receiver
//   tx_done      out  1  one-cycle pulse: frame sent and device ACK seen
//   tx_error     out  1  one-cycle pulse: no ACK or timeout
//   ps2_clk      in   1  raw PS/2 clock pin (asynchronous)
//   ps2_data     in   1  raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   out  1  1 = pull PS/2 clock low
//   ps2_data_oe  out  1  1 = pull PS/2 data low
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): state IDLE, all outputs 0 except tx_ready=1.
//   Both oe outputs are 0 (lines released). Counters cleared.
//   Reset mid-frame aborts at once, with no done or error pulse.
// - Input sync: ps2_clk and ps2_data each pass through 2 flops.
//   The falling edge is {last,cur}==2'b10 on the synced clock.
//   Edge detection lags the pin by 3 cycles.
// - Accept: on tx_valid&&tx_ready, latch tx_data into shift[7:0] and latch
//   par = ~^tx_data (odd parity). Go to INHIBIT; tx_ready=0 from the next cycle.
//   tx_valid while busy is ignored.
// - States and transitions:
//   IDLE    oe=00. Goes to INHIBIT on accept.
//   INHIBIT clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
//   RTS     clk_oe=1, data_oe=1 (start bit 0) for 1 cycle, then BITS with clk_oe=0.
//           The timeout counter is cleared here.
//   BITS    data_oe holds. On each ps2_clk falling edge, bit_cnt (0..9) increments:
//           edges 1-8 drive data_oe=~shift[n] for n=0..7, edge 9 drives
//           data_oe=~par, edge 10 sets data_oe=0 (stop bit). After edge 10, go to ACK.
//   ACK     On the next falling edge, sample synced ps2_data.
//           0 -> WAIT_REL; 1 -> tx_error pulse, then IDLE.
//   WAIT_REL Wait until synced ps2_clk==1 and ps2_data==1.
//           Then tx_done pulse and IDLE.
// - Timeout: counter is cleared on RTS and on every falling edge, and runs in
//   BITS, ACK and WAIT_REL. On reaching TIMEOUT_CYCLES: both oe=0, tx_error pulse,
//   IDLE. Counter width is clog2(TIMEOUT_CYCLES+1).
// - tx_done and tx_error are never high together. Either pulse is registered and
//   coincides with the first IDLE cycle (tx_ready=1 that cycle).
// - A falling edge and a timeout in the same cycle: the edge wins and the
//   counter clears.
// - ps2_clk_oe is high only in INHIBIT and RTS. ps2_data_oe is never high in
//   IDLE, INHIBIT, ACK or WAIT_REL.
// TESTING (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device BFM clocks at 40-cycle period)
// 1 Send 0xED, BFM ACKs: clk_oe high for exactly 20 cycles, then start bit 0.
//   Bits sampled on rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
//   Then one tx_done pulse; tx_error stays 0.
// 2 Send 0x00: parity bit sampled 1, stop 1; BFM ACKs -> tx_done.
//   Send 0xFF: parity 1 -> tx_done.
// 3 BFM leaves data high on the ACK clock -> one tx_error pulse, no tx_done,
//   both oe=0, tx_ready=1.
// 4 BFM never clocks after RTS -> tx_error exactly 200 cycles after clk_oe
//   releases, both oe=0.
// 5 rst_n low after 4 data bits -> next cycle oe=00, tx_ready=1, no pulses.
//   A new send of 0x5A then completes correctly.
// 6 tx_valid held high with 0x12 during a 0x34 frame -> only 0x34 is sent.
//   0x12 is taken once the frame is back in IDLE.

Source files
------------

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 send path.
// Lines are open-drain; an oe of 1 pulls the pin low.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_BITS,
    S_ACK,
    S_WAIT_REL
  } state_t;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          dbit, dbit_n;
  logic          done_n, error_n;
  logic          clk_s1, clk_s2, clk_last;
  logic          dat_s1, dat_s2;
  logic          fall, tmo;

  // Two-flop synchronisers; clk_last adds one more stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_last <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_last <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_last & ~clk_s2;
  assign tmo  = (tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shift    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      icnt     <= '0;
      tcnt     <= '0;
      dbit     <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      par      <= par_n;
      bit_cnt  <= bit_cnt_n;
      icnt     <= icnt_n;
      tcnt     <= tcnt_n;
      dbit     <= dbit_n;
      tx_done  <= done_n;
      tx_error <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    par_n     = par;
    bit_cnt_n = bit_cnt;
    icnt_n    = icnt;
    tcnt_n    = tcnt;
    dbit_n    = dbit;
    done_n    = 1'b0;
    error_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_n   = tx_data;
          par_n     = ~^tx_data;
          icnt_n    = '0;
          bit_cnt_n = '0;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (icnt == ILAST) begin
          state_n = S_RTS;
        end else begin
          icnt_n = icnt + IW'(1);
        end
      end
      S_RTS: begin
        tcnt_n    = '0;
        dbit_n    = 1'b1;
        bit_cnt_n = '0;
        state_n   = S_BITS;
      end
      S_BITS: begin
        if (fall) begin
          tcnt_n = '0;
          if (bit_cnt < 4'd8) begin
            dbit_n    = ~shift[bit_cnt[2:0]];
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (bit_cnt == 4'd8) begin
            dbit_n    = ~par;
            bit_cnt_n = bit_cnt + 4'd1;
          end else begin
            dbit_n    = 1'b0;
            bit_cnt_n = '0;
            state_n   = S_ACK;
          end
        end else if (tmo) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_ACK: begin
        if (fall) begin
          tcnt_n = '0;
          if (dat_s2) begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_REL;
          end
        end else if (tmo) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_WAIT_REL: begin
        if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (fall) begin
          tcnt_n = '0;
        end else if (tmo) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign tx_ready    = (state == S_IDLE);
  assign tx_busy     = (state != S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_RTS);
  assign ps2_data_oe = (state == S_RTS) || ((state == S_BITS) && dbit);

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: device-side BFM plus frame model for ps2_transmitter.
// Frames are decoded off the wire and compared with the byte's expected PS/2 frame.
module tb_ps2_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk, ps2_data;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int inh_run = 0;
  int rts_run = 0;
  int rel_cyc = 0;
  int err_cyc = 0;

  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Line values the device should see on its rising edges:
  // data LSB first, then a parity bit making the ones count odd, then stop=1.
  function automatic logic [9:0] model_bits(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'h01);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      inh_run = 0;
      rts_run = 0;
    end else begin
      check("ready_busy", 32'(tx_ready ^ tx_busy), 1);
      check("pulse_excl", 32'(tx_done & tx_error), 0);
      if (tx_ready) check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      if (tx_done || tx_error) check("pulse_idle", 32'(tx_ready), 1);
      if (tx_done) n_done++;
      if (tx_error) begin
        n_err++;
        err_cyc = cyc;
      end
      if (ps2_clk_oe && !ps2_data_oe) begin
        inh_run++;
      end else if (ps2_clk_oe && ps2_data_oe) begin
        if (rts_run == 0) check("inhibit_len", inh_run, INH);
        rts_run++;
      end else begin
        if (rts_run != 0) begin
          check("rts_len", rts_run, 1);
          rel_cyc = cyc;
        end
        inh_run = 0;
        rts_run = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    logic was;
    int n;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    do begin
      was = tx_ready;
      @(negedge clk);
      n++;
    end while (!was && n < 500);
    check("accept", 32'(tx_ready), 0);
    tx_valid = 1'b0;
  endtask

  task automatic device(input int nbits, input bit ack,
                        output logic [9:0] got, output logic start_ok);
    int n;
    got = '0;
    start_ok = 1'b0;
    n = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", 32'(n < 400), 1);
    if (n >= 400) return;
    n = 0;
    while (ps2_clk_oe && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    start_ok = ~ps2_data;
    for (int k = 0; k < nbits; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      got[k] = ps2_data;
      repeat (HALF) @(negedge clk);
    end
    if (nbits == 10) begin
      repeat (5) @(negedge clk);
      if (ack) dev_data = 1'b0;
      repeat (HALF - 5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit ack, input string tag,
                       output logic [9:0] got);
    logic st;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(b);
    device(10, ack, got, st);
    check({tag, "_start"}, 32'(st), 1);
    check({tag, "_bits"}, 32'(got), 32'(model_bits(b)));
    repeat (30) @(negedge clk);
    check({tag, "_done"}, n_done - d0, ack ? 1 : 0);
    check({tag, "_err"}, n_err - e0, ack ? 0 : 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] got;
    logic       st;
    logic       was;
    logic [7:0] rb;
    bit         rack;
    int         n, d0, e0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error},
          6'b100000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame(8'hED, 1'b1, "ed", got);
    check("ed_literal", 32'(got), 32'h3ED);
    frame(8'h00, 1'b1, "x00", got);
    check("x00_literal", 32'(got), 32'h300);
    frame(8'hFF, 1'b1, "xff", got);
    check("xff_literal", 32'(got), 32'h3FF);

    frame(8'hA7, 1'b0, "nack", got);
    check("nack_idle", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

    e0 = n_err;
    d0 = n_done;
    send(8'h55);
    n = 0;
    while (n_err == e0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("tmo_seen", n_err - e0, 1);
    check("tmo_delay", err_cyc - rel_cyc, 200);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_nodone", n_done - d0, 0);

    d0 = n_done;
    e0 = n_err;
    send(8'hC3);
    device(4, 1'b0, got, st);
    check("rst_part_bits", 32'(got[3:0]), 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort",
          {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_error}, 5'b00100);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
    frame(8'h5A, 1'b1, "x5a", got);

    d0 = n_done;
    @(negedge clk);
    tx_data  = 8'h34;
    tx_valid = 1'b1;
    n = 0;
    do begin
      was = tx_ready;
      @(negedge clk);
      n++;
    end while (!was && n < 500);
    tx_data = 8'h12;
    device(10, 1'b1, got, st);
    check("hold_bits34", 32'(got), 32'(model_bits(8'h34)));
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("hold_accept12", 32'(tx_ready), 0);
    tx_valid = 1'b0;
    check("hold_done34", n_done - d0, 1);
    device(10, 1'b1, got, st);
    check("hold_bits12", 32'(got), 32'(model_bits(8'h12)));
    repeat (30) @(negedge clk);
    check("hold_done12", n_done - d0, 2);

    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(255));
      rack = ($urandom_range(3) != 0);
      frame(rb, rack, "rand", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
